// File: rtl/ex_operand_forward_hold_if.sv
// Operand front-end bundle: forwarding hits/data, ID/EX operands, stage control and ALU/MEM results.
interface ex_operand_forward_hold_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FWD    = 2,
    parameter int CNT_WIDTH  = 16
);
    logic                          ex_valid;
    logic                          stall_EX;
    logic                          flush_EX;
    logic [NUM_FWD-1:0]            fwd_hit_rs1;
    logic [NUM_FWD-1:0]            fwd_hit_rs2;
    logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data;
    logic [DATA_WIDTH-1:0]         RD1D_ID_EX_o;
    logic [DATA_WIDTH-1:0]         RD2D_ID_EX_o;
    logic [DATA_WIDTH-1:0]         PC_ID_EX_o;
    logic [DATA_WIDTH-1:0]         imm_ID_EX_o;
    logic [1:0]                    alu_sel_rs1;
    logic [1:0]                    alu_sel_rs2;
    logic [DATA_WIDTH-1:0]         rs1_for_alu;
    logic [DATA_WIDTH-1:0]         rs2_for_alu;
    logic [DATA_WIDTH-1:0]         rs2_store_data;
    logic [CNT_WIDTH-1:0]          fwd_cnt_rs1;
    logic [CNT_WIDTH-1:0]          fwd_cnt_rs2;
    logic [CNT_WIDTH-1:0]          hold_cnt;

    modport master (
        output ex_valid, stall_EX, flush_EX, fwd_hit_rs1, fwd_hit_rs2, fwd_data,
               RD1D_ID_EX_o, RD2D_ID_EX_o, PC_ID_EX_o, imm_ID_EX_o, alu_sel_rs1, alu_sel_rs2,
        input  rs1_for_alu, rs2_for_alu, rs2_store_data, fwd_cnt_rs1, fwd_cnt_rs2, hold_cnt
    );

    modport slave (
        input  ex_valid, stall_EX, flush_EX, fwd_hit_rs1, fwd_hit_rs2, fwd_data,
               RD1D_ID_EX_o, RD2D_ID_EX_o, PC_ID_EX_o, imm_ID_EX_o, alu_sel_rs1, alu_sel_rs2,
        output rs1_for_alu, rs2_for_alu, rs2_store_data, fwd_cnt_rs1, fwd_cnt_rs2, hold_cnt
    );
endinterface

// File: rtl/ex_operand_forward_hold.sv
// EX operand forwarding + ALU operand select with per-operand hold across stalls.
// Optional perf counters enabled by defining FWD_PERF_CNT_EN.
//
// state | meaning
// LIVE  | operand follows forward hits / regfile value combinationally
// HELD  | operand comes from the hold register captured at stall entry
module ex_operand_forward_hold #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FWD    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    ex_operand_forward_hold_if.slave bus
);
    typedef enum logic {LIVE = 1'b0, HELD = 1'b1} hold_state_t;

    hold_state_t           state_q [2];
    hold_state_t           state_d [2];
    logic [DATA_WIDTH-1:0] hold_q  [2];
    logic [DATA_WIDTH-1:0] hold_d  [2];
    logic [NUM_FWD-1:0]    hit     [2];
    logic [DATA_WIDTH-1:0] rf_val  [2];
    logic [DATA_WIDTH-1:0] fwd_val [2];
    logic                  capture [2];

    assign hit[0]    = bus.fwd_hit_rs1;
    assign hit[1]    = bus.fwd_hit_rs2;
    assign rf_val[0] = bus.RD1D_ID_EX_o;
    assign rf_val[1] = bus.RD2D_ID_EX_o;

    // Scan from oldest to youngest so the lowest hit index ends up winning.
    always_comb begin
        for (int op = 0; op < 2; op++) begin
            fwd_val[op] = rf_val[op];
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (hit[op][i]) fwd_val[op] = bus.fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state_q[op] == HELD) fwd_val[op] = hold_q[op];
        end
    end

    always_comb begin
        for (int op = 0; op < 2; op++) begin
            state_d[op] = state_q[op];
            hold_d[op]  = hold_q[op];
            capture[op] = 1'b0;
            if (bus.flush_EX) begin
                state_d[op] = LIVE;
            end else begin
                case (state_q[op])
                    LIVE: begin
                        if (bus.ex_valid && bus.stall_EX && (|hit[op])) begin
                            state_d[op] = HELD;
                            hold_d[op]  = fwd_val[op];
                            capture[op] = 1'b1;
                        end
                    end
                    HELD: begin
                        if (!bus.stall_EX) state_d[op] = LIVE;
                    end
                    default: state_d[op] = LIVE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int op = 0; op < 2; op++) begin
            if (rst) begin
                state_q[op] <= LIVE;
                hold_q[op]  <= '0;
            end else begin
                state_q[op] <= state_d[op];
                hold_q[op]  <= hold_d[op];
            end
        end
    end

    always_comb begin
        case (bus.alu_sel_rs1)
            2'd0:    bus.rs1_for_alu = fwd_val[0];
            2'd1:    bus.rs1_for_alu = bus.PC_ID_EX_o;
            default: bus.rs1_for_alu = '0;
        endcase
        case (bus.alu_sel_rs2)
            2'd0:    bus.rs2_for_alu = fwd_val[1];
            2'd1:    bus.rs2_for_alu = bus.imm_ID_EX_o;
            2'd2:    bus.rs2_for_alu = DATA_WIDTH'(4);
            default: bus.rs2_for_alu = '0;
        endcase
    end

    assign bus.rs2_store_data = fwd_val[1];

`ifdef FWD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_rs1_q, cnt_rs2_q, cnt_hold_q;
    logic                 advance, inc_rs1, inc_rs2, inc_hold;

    // No store indicator reaches this block, so rs2 counts only sel 0 consumption.
    assign advance  = bus.ex_valid && !bus.stall_EX && !bus.flush_EX;
    assign inc_rs1  = advance && (bus.alu_sel_rs1 == 2'd0) && ((state_q[0] == HELD) || (|hit[0]));
    assign inc_rs2  = advance && (bus.alu_sel_rs2 == 2'd0) && ((state_q[1] == HELD) || (|hit[1]));
    assign inc_hold = capture[0] || capture[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_rs1_q  <= '0;
            cnt_rs2_q  <= '0;
            cnt_hold_q <= '0;
        end else begin
            if (inc_rs1 && !(&cnt_rs1_q))   cnt_rs1_q  <= cnt_rs1_q + CNT_WIDTH'(1);
            if (inc_rs2 && !(&cnt_rs2_q))   cnt_rs2_q  <= cnt_rs2_q + CNT_WIDTH'(1);
            if (inc_hold && !(&cnt_hold_q)) cnt_hold_q <= cnt_hold_q + CNT_WIDTH'(1);
        end
    end

    assign bus.fwd_cnt_rs1 = cnt_rs1_q;
    assign bus.fwd_cnt_rs2 = cnt_rs2_q;
    assign bus.hold_cnt    = cnt_hold_q;
`else
    assign bus.fwd_cnt_rs1 = {CNT_WIDTH{1'b0}};
    assign bus.fwd_cnt_rs2 = {CNT_WIDTH{1'b0}};
    assign bus.hold_cnt    = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_ex_operand_forward_hold.sv
// Bench for ex_operand_forward_hold: directed literal cases plus randomized traffic vs. a reference model.
module tb_ex_operand_forward_hold;
    localparam int DW = 32;
    localparam int NF = 2;
`ifdef FWD_PERF_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif
    localparam longint CMAX = (64'd1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_operand_forward_hold_if #(.DATA_WIDTH(DW), .NUM_FWD(NF), .CNT_WIDTH(CW)) bus ();
    ex_operand_forward_hold #(.DATA_WIDTH(DW), .NUM_FWD(NF), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    bit          m_held [2];
    logic [31:0] m_hval [2];
    longint      m_cnt1, m_cnt2, m_hcnt;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_fwd(int op);
        logic [1:0] h;
        h = (op == 0) ? bus.fwd_hit_rs1 : bus.fwd_hit_rs2;
        if (m_held[op]) return m_hval[op];
        for (int i = 0; i < NF; i++)
            if (h[i]) return bus.fwd_data[i*DW +: DW];
        return (op == 0) ? bus.RD1D_ID_EX_o : bus.RD2D_ID_EX_o;
    endfunction

    function automatic longint sat_inc(longint v);
        return (v == CMAX) ? CMAX : v + 1;
    endfunction

    // Reference model state update.
    always @(posedge clk) begin
        logic [31:0] v [2];
        bit          any_hit [2];
        bit          cap;
        bit          adv;
        v[0] = m_fwd(0);
        v[1] = m_fwd(1);
        any_hit[0] = |bus.fwd_hit_rs1;
        any_hit[1] = |bus.fwd_hit_rs2;
        if (rst) begin
            m_held = '{0, 0};
            m_hval = '{0, 0};
            m_cnt1 = 0; m_cnt2 = 0; m_hcnt = 0;
        end else begin
            cap = 0;
            adv = bus.ex_valid && !bus.stall_EX && !bus.flush_EX;
`ifdef FWD_PERF_CNT_EN
            if (adv && bus.alu_sel_rs1 == 0 && (m_held[0] || any_hit[0])) m_cnt1 = sat_inc(m_cnt1);
            if (adv && bus.alu_sel_rs2 == 0 && (m_held[1] || any_hit[1])) m_cnt2 = sat_inc(m_cnt2);
`endif
            for (int op = 0; op < 2; op++) begin
                if (bus.flush_EX) m_held[op] = 0;
                else if (m_held[op]) m_held[op] = bus.stall_EX;
                else if (bus.ex_valid && bus.stall_EX && any_hit[op]) begin
                    m_held[op] = 1;
                    m_hval[op] = v[op];
                    cap = 1;
                end
            end
`ifdef FWD_PERF_CNT_EN
            if (cap) m_hcnt = sat_inc(m_hcnt);
`endif
        end
    end

    // Compare process: outputs are combinational, sampled mid-cycle.
    always @(negedge clk) begin
        logic [31:0] e1, e2;
        if (chk_en) begin
            case (bus.alu_sel_rs1)
                2'd0: e1 = m_fwd(0);
                2'd1: e1 = bus.PC_ID_EX_o;
                default: e1 = 32'h0;
            endcase
            case (bus.alu_sel_rs2)
                2'd0: e2 = m_fwd(1);
                2'd1: e2 = bus.imm_ID_EX_o;
                2'd2: e2 = 32'd4;
                default: e2 = 32'h0;
            endcase
            check("model_rs1_for_alu", bus.rs1_for_alu, e1);
            check("model_rs2_for_alu", bus.rs2_for_alu, e2);
            check("model_rs2_store_data", bus.rs2_store_data, m_fwd(1));
            check("model_fwd_cnt_rs1", 32'(bus.fwd_cnt_rs1), 32'(m_cnt1));
            check("model_fwd_cnt_rs2", 32'(bus.fwd_cnt_rs2), 32'(m_cnt2));
            check("model_hold_cnt", 32'(bus.hold_cnt), 32'(m_hcnt));
        end
    end

    task automatic idle();
        bus.ex_valid = 1; bus.stall_EX = 0; bus.flush_EX = 0;
        bus.fwd_hit_rs1 = '0; bus.fwd_hit_rs2 = '0; bus.fwd_data = '0;
        bus.RD1D_ID_EX_o = '0; bus.RD2D_ID_EX_o = '0;
        bus.PC_ID_EX_o = '0; bus.imm_ID_EX_o = '0;
        bus.alu_sel_rs1 = 2'd0; bus.alu_sel_rs2 = 2'd0;
    endtask

    task automatic step_in();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_cnt1 = 0; m_cnt2 = 0; m_hcnt = 0;
        m_held = '{0, 0};
        m_hval = '{0, 0};
        step_in();
        step_in();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state: stalled with no hit, regfile value passes straight through.
        bus.stall_EX = 1; bus.RD1D_ID_EX_o = 32'h55;
        @(negedge clk);
        check("reset_rs1_live", bus.rs1_for_alu, 32'h55);
        check("reset_hold_cnt", 32'(bus.hold_cnt), 32'h0);

        // 1: single hit from youngest source.
        step_in(); idle();
        bus.fwd_hit_rs1 = 2'b01; bus.fwd_data[31:0] = 32'h1111_0000;
        @(negedge clk);
        check("t1_rs1_fwd_src0", bus.rs1_for_alu, 32'h1111_0000);

        // 2: both hit, youngest wins.
        step_in(); idle();
        bus.fwd_hit_rs1 = 2'b11; bus.fwd_data = {32'h5555_5555, 32'hAAAA_AAAA};
        @(negedge clk);
        check("t2_rs1_youngest", bus.rs1_for_alu, 32'hAAAA_AAAA);

        // 3: rs2 captured from WB source survives its retirement.
        step_in(); idle();
        bus.stall_EX = 1; bus.fwd_hit_rs2 = 2'b10; bus.fwd_data = {32'hDEAD_BEEF, 32'h0};
        @(negedge clk);
        check("t3_rs2_c0", bus.rs2_for_alu, 32'hDEAD_BEEF);
        for (int c = 1; c <= 3; c++) begin
            step_in();
            bus.fwd_hit_rs2 = 2'b00; bus.fwd_data = {32'h0BAD_0BAD, 32'h1357_9BDF};
            bus.stall_EX = (c < 3);
            @(negedge clk);
            check("t3_rs2_held", bus.rs2_for_alu, 32'hDEAD_BEEF);
            check("t3_store_held", bus.rs2_store_data, 32'hDEAD_BEEF);
        end
        step_in(); idle();
        bus.RD2D_ID_EX_o = 32'h0000_0042;
        @(negedge clk);
        check("t3_rs2_live_after", bus.rs2_for_alu, 32'h0000_0042);

        // 4: flush while held and stalled returns rs1 to LIVE without capture.
        step_in(); idle();
        bus.stall_EX = 1; bus.fwd_hit_rs1 = 2'b01; bus.fwd_data[31:0] = 32'h1234;
        step_in();
        bus.fwd_hit_rs1 = 2'b00; bus.fwd_data = '0; bus.flush_EX = 1;
        @(negedge clk);
        check("t4_rs1_held_in_flush", bus.rs1_for_alu, 32'h1234);
        step_in();
        bus.flush_EX = 0; bus.RD1D_ID_EX_o = 32'hCAFE_F00D;
        @(negedge clk);
        check("t4_rs1_live_after_flush", bus.rs1_for_alu, 32'hCAFE_F00D);

        // 5: operand selects.
        step_in(); idle();
        bus.alu_sel_rs1 = 2'd1; bus.PC_ID_EX_o = 32'h0000_0100;
        bus.alu_sel_rs2 = 2'd2; bus.fwd_hit_rs2 = 2'b01; bus.fwd_data[31:0] = 32'h77;
        @(negedge clk);
        check("t5_rs1_pc", bus.rs1_for_alu, 32'h0000_0100);
        check("t5_rs2_const4", bus.rs2_for_alu, 32'd4);
        check("t5_store_fwd", bus.rs2_store_data, 32'h77);
        step_in();
        bus.alu_sel_rs1 = 2'd3; bus.alu_sel_rs2 = 2'd3;
        @(negedge clk);
        check("t5_rs1_zero", bus.rs1_for_alu, 32'h0);
        check("t5_rs2_zero", bus.rs2_for_alu, 32'h0);

`ifdef FWD_PERF_CNT_EN
        // 6: counter saturation then reset.
        step_in(); idle(); rst = 1;
        step_in(); rst = 0;
        bus.fwd_hit_rs1 = 2'b01; bus.fwd_data[31:0] = 32'h9;
        repeat (20) step_in();
        idle();
        @(negedge clk);
        check("t6_cnt_saturated", 32'(bus.fwd_cnt_rs1), 32'hF);
        step_in(); rst = 1;
        step_in(); rst = 0;
        @(negedge clk);
        check("t6_cnt_reset", 32'(bus.fwd_cnt_rs1), 32'h0);
`endif

        // Randomized traffic, stall-heavy so holds are exercised.
        for (int c = 0; c < 3000; c++) begin
            step_in();
            rst              = ($urandom_range(0, 99) == 0);
            bus.ex_valid     = ($urandom_range(0, 9) != 0);
            bus.stall_EX     = ($urandom_range(0, 2) != 0);
            bus.flush_EX     = ($urandom_range(0, 9) == 0);
            bus.fwd_hit_rs1  = 2'($urandom_range(0, 3));
            bus.fwd_hit_rs2  = 2'($urandom_range(0, 3));
            bus.fwd_data     = {$urandom, $urandom};
            bus.RD1D_ID_EX_o = $urandom;
            bus.RD2D_ID_EX_o = $urandom;
            bus.PC_ID_EX_o   = $urandom;
            bus.imm_ID_EX_o  = $urandom;
            bus.alu_sel_rs1  = 2'($urandom_range(0, 3));
            bus.alu_sel_rs2  = 2'($urandom_range(0, 3));
        end
        step_in();
        rst = 0;
        idle();
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
